register_file_scoreboard: RTL and testbench
===========================================

// Module: register_file_scoreboard
// PURPOSE
//  Parametrised 2-read/1-write register file for the pipelined datapath, with write-to-read bypass and a busy-bit scoreboard.
//  Decode reads operands and busy flags; issue marks a destination pending; writeback stores data and clears pending.
//  Register 0 is hardwired to zero. Hazard/stall logic sits outside and consumes readBusy1/2.
// PARAMETERS
//  DATA_W   8   data width of each register
//  ADDR_W   3   register address width; depth = 2**ADDR_W
//  BYPASS   1   1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
// PORTS
//  clock          in   1            single clock, rising edge
//  reset          in   1            asynchronous, active-high; clears all state
//  readRegister1  in   ADDR_W       read port 1 address
//  readRegister2  in   ADDR_W       read port 2 address
//  readData1      out  DATA_W       read port 1 data (combinational)
//  readData2      out  DATA_W       read port 2 data (combinational)
//  readBusy1      out  1            read port 1 register pending (combinational)
//  readBusy2      out  1            read port 2 register pending (combinational)
//  issueValid     in   1            instruction issued with destination issueRegister
//  issueRegister  in   ADDR_W       destination to mark busy
//  regWrite       in   1            writeback strobe
//  writeRegister  in   ADDR_W       writeback destination
//  writeData      in   DATA_W       writeback data
//  busyCount      out  ADDR_W+1     registered count of busy registers
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-write): all registers 0, all busy bits 0, busyCount 0; readData* = 0, readBusy* = 0 while held.
//  - Write: regWrite && writeRegister!=0 -> register updated at rising edge (1-cycle latency to storage).
//  - Read: combinational mux. readRegisterN==0 -> readDataN = 0, readBusyN = 0, regardless of writes.
//  - Bypass (BYPASS=1): regWrite && writeRegister==readRegisterN && !=0 -> readDataN = writeData and readBusyN = 0 same cycle.
//  - BYPASS=0: readDataN = stored value, readBusyN = busy bit as stored.
//  - Scoreboard, at each rising edge, per register r != 0:
//      set   = issueValid && issueRegister==r;  clr = regWrite && writeRegister==r
//      set&&clr -> busy[r]=1 (new producer wins); set -> 1; clr -> 0; else hold.
//  - Issue to an already-busy register (WAW): busy stays 1, no count change.
//  - Writeback to a non-busy register: data written, busy stays 0, no count change.
//  - Issue/write to register 0: ignored; busy[0] is constant 0.
//  - busyCount next = busyCount + (set taking a 0->1) - (clr taking a 1->0); +1 and -1 on different registers nets to 0.
//    Never exceeds 2**ADDR_W-1; no wrap possible; an assertion flags any underflow/overflow.
//  - No state machine beyond per-register busy flags and the counter; all state is edge-triggered except reset.
// STRUCTURE
//  - Shared header regfile_defs: DATA_W/ADDR_W defaults, ZERO_REG constant (0).
//  - Sub-module busy_scoreboard (busy vector, set/clear priority, busyCount, per-port busy lookup);
//    storage array, read muxes and bypass live in the top.
// TESTING
//  1 Reset mid-run: write 8'hAA to r3, assert reset between edges -> readData1(r3)=0, busyCount=0 immediately.
//  2 Write r5=8'h3C, read r5 next cycle -> 8'h3C; same-cycle read with BYPASS=1 -> 8'h3C, BYPASS=0 -> old value 0.
//  3 Write 8'hFF to r0 -> readData(r0)=0; issue r0 -> readBusy=0, busyCount unchanged.
//  4 Issue r2 -> next cycle readBusy1(r2)=1, busyCount=1; writeback r2 -> readBusy1 drops same cycle (bypass), busyCount=0 after edge.
//  5 Same edge: issue r4 and writeback r4 (r4 busy) -> r4 stays busy, busyCount unchanged; issue r6 + writeback r1 (busy) -> count unchanged.
//  6 Issue r1..r7 back-to-back -> busyCount=7; re-issue r3 -> stays 7; write back all seven -> busyCount=0, no underflow.

Source files
------------

// File: rtl/register_file_scoreboard_pkg.sv
// rtl/register_file_scoreboard_pkg.sv - shared register-file defaults and the hardwired zero register
package register_file_scoreboard_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;
   localparam int ZERO_REG   = 0;
endpackage

// File: rtl/register_file_scoreboard_busy_scoreboard.sv
// rtl/register_file_scoreboard_busy_scoreboard.sv - per-register pending bits, busy count and per-port busy lookup
module busy_scoreboard
   import register_file_scoreboard_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
)
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_set_valid,
   input  logic [ADDR_W-1:0] i_set_reg,
   input  logic              i_clr_valid,
   input  logic [ADDR_W-1:0] i_clr_reg,
   input  logic [ADDR_W-1:0] i_rd_reg1,
   input  logic [ADDR_W-1:0] i_rd_reg2,
   output logic              o_busy1,
   output logic              o_busy2,
   output logic [ADDR_W:0]   o_busy_count
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_next;
   logic [ADDR_W:0]  r_busy_count;
   logic [ADDR_W:0]  w_count_next;
   logic             w_inc;
   logic             w_dec;

   // A new producer outranks a retiring one on the same register.
   always_comb begin
      w_busy_next = r_busy;
      w_inc       = 1'b0;
      w_dec       = 1'b0;
      for (int r = 1; r < DEPTH; r++) begin
         if (i_set_valid && (i_set_reg == ADDR_W'(r))) begin
            w_busy_next[r] = 1'b1;
            if (!r_busy[r]) w_inc = 1'b1;
         end else if (i_clr_valid && (i_clr_reg == ADDR_W'(r))) begin
            w_busy_next[r] = 1'b0;
            if (r_busy[r]) w_dec = 1'b1;
         end
      end
      w_busy_next[ZERO_REG] = 1'b0;
      w_count_next = r_busy_count + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy       <= '0;
         r_busy_count <= '0;
      end else begin
         r_busy       <= w_busy_next;
         r_busy_count <= w_count_next;
      end
   end

   assign o_busy1      = r_busy[i_rd_reg1];
   assign o_busy2      = r_busy[i_rd_reg2];
   assign o_busy_count = r_busy_count;

   a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(w_dec && !w_inc && (r_busy_count == '0)));
   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(w_inc && !w_dec && (r_busy_count == (ADDR_W+1)'(DEPTH-1))));
endmodule

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - 2R/1W register file with write-to-read bypass and busy scoreboard
module register_file_scoreboard
   import register_file_scoreboard_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int BYPASS = 1
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] readRegister1,
   input  logic [ADDR_W-1:0] readRegister2,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2,
   output logic              readBusy1,
   output logic              readBusy2,
   input  logic              issueValid,
   input  logic [ADDR_W-1:0] issueRegister,
   input  logic              regWrite,
   input  logic [ADDR_W-1:0] writeRegister,
   input  logic [DATA_W-1:0] writeData,
   output logic [ADDR_W:0]   busyCount
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_wr_en;
   logic              w_busy1;
   logic              w_busy2;
   logic              w_hit1;
   logic              w_hit2;

   assign w_wr_en = regWrite && (writeRegister != ZERO_ADDR);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr_en) begin
         r_mem[writeRegister] <= writeData;
      end
   end

   busy_scoreboard #(.ADDR_W(ADDR_W)) u_busy (
      .i_clk        (clock),
      .i_rst        (reset),
      .i_set_valid  (issueValid),
      .i_set_reg    (issueRegister),
      .i_clr_valid  (regWrite),
      .i_clr_reg    (writeRegister),
      .i_rd_reg1    (readRegister1),
      .i_rd_reg2    (readRegister2),
      .o_busy1      (w_busy1),
      .o_busy2      (w_busy2),
      .o_busy_count (busyCount)
   );

   // Forwarding a same-cycle writeback also hides the pending bit it is about to clear.
   assign w_hit1 = (BYPASS != 0) && w_wr_en && (writeRegister == readRegister1);
   assign w_hit2 = (BYPASS != 0) && w_wr_en && (writeRegister == readRegister2);

   always_comb begin
      readData1 = '0;
      readBusy1 = 1'b0;
      if (!reset && (readRegister1 != ZERO_ADDR)) begin
         readData1 = w_hit1 ? writeData : r_mem[readRegister1];
         readBusy1 = w_busy1 && !w_hit1;
      end
   end

   always_comb begin
      readData2 = '0;
      readBusy2 = 1'b0;
      if (!reset && (readRegister2 != ZERO_ADDR)) begin
         readData2 = w_hit2 ? writeData : r_mem[readRegister2];
         readBusy2 = w_busy2 && !w_hit2;
      end
   end
endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb/tb_register_file_scoreboard.sv - directed bench for register_file_scoreboard, bypass and non-bypass builds
module tb_register_file_scoreboard;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] rr1 = '0, rr2 = '0, ir = '0, wr = '0;
   logic       iv = 1'b0, rw = 1'b0;
   logic [7:0] wd = '0;

   logic [7:0] b_rd1, b_rd2, n_rd1, n_rd2;
   logic       b_bz1, b_bz2, n_bz1, n_bz2;
   logic [3:0] b_cnt, n_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   register_file_scoreboard #(.DATA_W(8), .ADDR_W(3), .BYPASS(1)) u_byp (
      .clock(clock), .reset(reset),
      .readRegister1(rr1), .readRegister2(rr2),
      .readData1(b_rd1), .readData2(b_rd2),
      .readBusy1(b_bz1), .readBusy2(b_bz2),
      .issueValid(iv), .issueRegister(ir),
      .regWrite(rw), .writeRegister(wr), .writeData(wd),
      .busyCount(b_cnt)
   );

   register_file_scoreboard #(.DATA_W(8), .ADDR_W(3), .BYPASS(0)) u_nobyp (
      .clock(clock), .reset(reset),
      .readRegister1(rr1), .readRegister2(rr2),
      .readData1(n_rd1), .readData2(n_rd2),
      .readBusy1(n_bz1), .readBusy2(n_bz2),
      .issueValid(iv), .issueRegister(ir),
      .regWrite(rw), .writeRegister(wr), .writeData(wd),
      .busyCount(n_cnt)
   );

   // Architectural state: register contents and set of pending destinations.
   logic [7:0] m_reg [8];
   bit         m_busy [8];

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (rw && wr != 0) begin
            m_reg[wr]  = wd;
            m_busy[wr] = 1'b0;
         end
         if (iv && ir != 0) m_busy[ir] = 1'b1;
      end
   end

   function automatic logic [7:0] exp_data(input bit byp, input logic [2:0] rr);
      if (reset || rr == 0) return 8'h00;
      if (byp && rw && wr == rr) return wd;
      return m_reg[rr];
   endfunction

   function automatic logic exp_busy(input bit byp, input logic [2:0] rr);
      if (reset || rr == 0) return 1'b0;
      if (byp && rw && wr == rr) return 1'b0;
      return m_busy[rr];
   endfunction

   function automatic logic [3:0] exp_count();
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(m_busy[i]);
      return 4'(n);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clock) begin
      chk("byp_rd1",  32'(b_rd1), 32'(exp_data(1'b1, rr1)));
      chk("byp_rd2",  32'(b_rd2), 32'(exp_data(1'b1, rr2)));
      chk("byp_bz1",  32'(b_bz1), 32'(exp_busy(1'b1, rr1)));
      chk("byp_bz2",  32'(b_bz2), 32'(exp_busy(1'b1, rr2)));
      chk("byp_cnt",  32'(b_cnt), 32'(exp_count()));
      chk("nbyp_rd1", 32'(n_rd1), 32'(exp_data(1'b0, rr1)));
      chk("nbyp_rd2", 32'(n_rd2), 32'(exp_data(1'b0, rr2)));
      chk("nbyp_bz1", 32'(n_bz1), 32'(exp_busy(1'b0, rr1)));
      chk("nbyp_bz2", 32'(n_bz2), 32'(exp_busy(1'b0, rr2)));
      chk("nbyp_cnt", 32'(n_cnt), 32'(exp_count()));
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      iv = 1'b0; ir = '0; rw = 1'b0; wr = '0; wd = '0;
   endtask

   initial begin
      step(); step();
      chk("rst_cnt", 32'(b_cnt), 32'd0);
      chk("rst_rd1", 32'(b_rd1), 32'd0);
      reset = 1'b0;

      // write r5 with same-cycle read on both builds
      rr1 = 3'd5; rw = 1'b1; wr = 3'd5; wd = 8'h3C;
      #2;
      chk("t2_byp_same",  32'(b_rd1), 32'h3C);
      chk("t2_nbyp_same", 32'(n_rd1), 32'h00);
      step(); idle();
      #2;
      chk("t2_byp_next",  32'(b_rd1), 32'h3C);
      chk("t2_nbyp_next", 32'(n_rd1), 32'h3C);

      // register 0 is immune to writes and issues
      rr1 = 3'd0; rw = 1'b1; wr = 3'd0; wd = 8'hFF;
      #2;
      chk("t3_r0_same", 32'(b_rd1), 32'h00);
      step(); idle();
      iv = 1'b1; ir = 3'd0;
      step(); idle();
      #2;
      chk("t3_r0_busy", 32'(b_bz1), 32'd0);
      chk("t3_r0_cnt",  32'(b_cnt), 32'd0);

      // reset asserted between edges with live state
      rr1 = 3'd3; rw = 1'b1; wr = 3'd3; wd = 8'hAA; iv = 1'b1; ir = 3'd5;
      step(); idle();
      #2;
      chk("t1_pre_rd",  32'(b_rd1), 32'hAA);
      chk("t1_pre_cnt", 32'(b_cnt), 32'd1);
      reset = 1'b1;
      #1;
      chk("t1_rst_rd",   32'(b_rd1), 32'h00);
      chk("t1_rst_cnt",  32'(b_cnt), 32'd0);
      chk("t1_rst_nrd",  32'(n_rd1), 32'h00);
      step();
      reset = 1'b0;

      // issue then writeback r2
      iv = 1'b1; ir = 3'd2;
      step(); idle();
      rr1 = 3'd2; rr2 = 3'd2;
      #2;
      chk("t4_busy", 32'(b_bz1), 32'd1);
      chk("t4_cnt",  32'(b_cnt), 32'd1);
      rw = 1'b1; wr = 3'd2; wd = 8'h11;
      #2;
      chk("t4_byp_drop",  32'(b_bz1), 32'd0);
      chk("t4_nbyp_hold", 32'(n_bz1), 32'd1);
      step(); idle();
      #2;
      chk("t4_cnt_after", 32'(b_cnt), 32'd0);

      // simultaneous issue and writeback
      iv = 1'b1; ir = 3'd4;
      step(); idle();
      iv = 1'b1; ir = 3'd4; rw = 1'b1; wr = 3'd4; wd = 8'h44;
      step(); idle();
      rr1 = 3'd4;
      #2;
      chk("t5_r4_busy", 32'(b_bz1), 32'd1);
      chk("t5_cnt1",    32'(b_cnt), 32'd1);
      iv = 1'b1; ir = 3'd1;
      step(); idle();
      iv = 1'b1; ir = 3'd6; rw = 1'b1; wr = 3'd1; wd = 8'h61;
      step(); idle();
      #2;
      chk("t5_cnt2", 32'(b_cnt), 32'd2);
      rw = 1'b1; wr = 3'd4; wd = 8'h45;
      step();
      wr = 3'd6; wd = 8'h66;
      step(); idle();
      #2;
      chk("t5_cnt0", 32'(b_cnt), 32'd0);

      // fill, WAW re-issue, drain
      for (int r = 1; r < 8; r++) begin
         iv = 1'b1; ir = 3'(r); rr2 = 3'(r);
         step();
      end
      idle();
      #2;
      chk("t6_full", 32'(b_cnt), 32'd7);
      iv = 1'b1; ir = 3'd3;
      step(); idle();
      #2;
      chk("t6_waw", 32'(b_cnt), 32'd7);
      for (int r = 1; r < 8; r++) begin
         rw = 1'b1; wr = 3'(r); wd = 8'((r << 4) | r); rr1 = 3'(r);
         step();
      end
      idle();
      #2;
      chk("t6_drain", 32'(b_cnt), 32'd0);
      rw = 1'b1; wr = 3'd5; wd = 8'h5A; rr1 = 3'd5; rr2 = 3'd7;
      step(); idle();
      #2;
      chk("t6_nonbusy_cnt", 32'(b_cnt), 32'd0);
      chk("t6_r5",          32'(n_rd1), 32'h5A);
      chk("t6_r7",          32'(n_rd2), 32'h77);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
